// File: rtl/rop_frag_scheduler_pkg.sv
// ============================================================================
// Module      : rop_frag_scheduler_pkg
// Description : Shared types for the ROP fragment scheduler. Holds the
//               warp-wide request record (per-lane arrays plus thread mask),
//               the single-fragment record sent to the ROP pipeline, the
//               scheduler state encoding and a lowest-set-lane helper.
//               Lane count follows `NUM_THREADS (4 when not defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

package rop_frag_scheduler_pkg;

    localparam int NUM_LANES          = `NUM_THREADS;
    localparam int LANE_BITS          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int POS_BITS           = 12;
    localparam int DEPTH_BITS         = 24;
    localparam int ROP_SCHED_INFLIGHT = 8;
    localparam int ROP_SCHED_TAG_BITS = $clog2(ROP_SCHED_INFLIGHT);

    typedef struct packed {
        logic [NUM_LANES-1:0]                 tmask;
        logic [NUM_LANES-1:0][POS_BITS-1:0]   pos_x;
        logic [NUM_LANES-1:0][POS_BITS-1:0]   pos_y;
        logic [NUM_LANES-1:0][31:0]           color;
        logic [NUM_LANES-1:0][DEPTH_BITS-1:0] depth;
        logic [NUM_LANES-1:0]                 backface;
    } rop_req_t;

    typedef struct packed {
        logic [POS_BITS-1:0]   pos_x;
        logic [POS_BITS-1:0]   pos_y;
        logic [31:0]           color;
        logic [DEPTH_BITS-1:0] depth;
        logic                  backface;
    } rop_frag_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } sched_state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [LANE_BITS-1:0] lowest_lane(input logic [NUM_LANES-1:0] mask);
        lowest_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i]) lowest_lane = LANE_BITS'(i);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/rop_frag_scheduler_inflight.sv
// ============================================================================
// Module      : rop_inflight_table
// Description : In-flight fragment table. Each entry holds a valid bit and the
//               pixel position of a fragment owned by the ROP. Provides a
//               position CAM (hazard), full flag, lowest-free index for
//               allocation, and free-by-tag.
// Ports       : i_query_x/y  position to check against valid entries
//               i_alloc/_tag set entry valid and store query position
//               i_free/_tag  clear entry valid
//               o_hazard     some valid entry matches query position
//               o_full       every entry valid
//               o_free_tag   lowest invalid entry
//               o_any_valid  at least one entry valid
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rop_inflight_table
    import rop_frag_scheduler_pkg::*;
#(
    parameter int INFLIGHT = ROP_SCHED_INFLIGHT,
    parameter int TAG_BITS = $clog2(INFLIGHT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [POS_BITS-1:0] i_query_x,
    input  logic [POS_BITS-1:0] i_query_y,
    input  logic                i_alloc,
    input  logic [TAG_BITS-1:0] i_alloc_tag,
    input  logic                i_free,
    input  logic [TAG_BITS-1:0] i_free_tag,
    output logic                o_hazard,
    output logic                o_full,
    output logic                o_any_valid,
    output logic [TAG_BITS-1:0] o_free_tag
);

    logic [INFLIGHT-1:0] r_valid;
    logic [POS_BITS-1:0] r_pos_x [INFLIGHT];
    logic [POS_BITS-1:0] r_pos_y [INFLIGHT];
    logic [INFLIGHT-1:0] w_match;

    for (genvar i = 0; i < INFLIGHT; i++) begin : g_entry
        assign w_match[i] = r_valid[i] && (r_pos_x[i] == i_query_x) && (r_pos_y[i] == i_query_y);
    end

    assign o_hazard    = |w_match;
    assign o_full      = &r_valid;
    assign o_any_valid = |r_valid;

    always_comb begin
        o_free_tag = '0;
        for (int i = INFLIGHT - 1; i >= 0; i--) begin
            if (!r_valid[i]) o_free_tag = TAG_BITS'(i);
        end
    end

    // Allocation is written after the free so an allocation always lands;
    // the allocating tag comes from the pre-edge free set, so it never
    // collides with a legitimate same-cycle free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            if (i_free)  r_valid[i_free_tag]  <= 1'b0;
            if (i_alloc) r_valid[i_alloc_tag] <= 1'b1;
        end
    end

    // Position payload is qualified by r_valid and needs no reset.
    always_ff @(posedge clk) begin
        if (i_alloc) begin
            r_pos_x[i_alloc_tag] <= i_query_x;
            r_pos_y[i_alloc_tag] <= i_query_y;
        end
    end

    a_free_valid_entry: assert property (@(posedge clk) disable iff (reset)
        i_free |-> r_valid[i_free_tag]);

endmodule

`default_nettype wire

// File: rtl/rop_frag_scheduler.sv
// ============================================================================
// Module      : rop_frag_scheduler
// Description : Round-robins NUM_REQS warp-wide ROP requests, serializes the
//               active lanes into one fragment per cycle and blocks any
//               fragment whose pixel is already in flight. Issued fragments
//               carry an in-flight tag that the ROP returns on completion.
// Ports       : req_valid/ready/data  per-port request handshake
//               frag_valid/ready      fragment handshake to the ROP
//               frag_data/frag_tag    fragment payload and in-flight tag
//               done_valid/done_tag   completion from the ROP, frees a tag
//               busy                  request being issued or entry in flight
// Config      : ROP_SCHED_PERF_EN adds perf_frags, perf_hazard_stalls and
//               perf_full_stalls 32-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rop_frag_scheduler
    import rop_frag_scheduler_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int INFLIGHT = ROP_SCHED_INFLIGHT,
    parameter int TAG_BITS = $clog2(INFLIGHT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid,
    output logic [NUM_REQS-1:0]           req_ready,
    input  rop_req_t [NUM_REQS-1:0]       req_data,
    output logic                          frag_valid,
    input  logic                          frag_ready,
    output rop_frag_t                     frag_data,
    output logic [TAG_BITS-1:0]           frag_tag,
    input  logic                          done_valid,
    input  logic [TAG_BITS-1:0]           done_tag,
    output logic                          busy
`ifdef ROP_SCHED_PERF_EN
    ,
    output logic [31:0]                   perf_frags,
    output logic [31:0]                   perf_hazard_stalls,
    output logic [31:0]                   perf_full_stalls
`endif
);

    localparam int PTR_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    sched_state_e           r_state;
    logic [PTR_BITS-1:0]    r_rr_ptr;
    rop_req_t               r_hold;        // r_hold.tmask is the remaining-lane mask
    logic                   r_tag_locked;
    logic [TAG_BITS-1:0]    r_tag_lock;

    logic                   w_grant_found;
    logic [PTR_BITS-1:0]    w_grant_idx;
    logic [PTR_BITS-1:0]    w_next_ptr;
    logic                   w_accept;
    logic [LANE_BITS-1:0]   w_lane;
    logic [NUM_LANES-1:0]   w_mask_next;
    logic                   w_hazard;
    logic                   w_full;
    logic                   w_any_valid;
    logic [TAG_BITS-1:0]    w_free_tag;
    logic                   w_fire;

    // Round-robin pick starting at r_rr_ptr.
    always_comb begin : p_rr
        int v_sum;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        v_sum         = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            v_sum = int'(r_rr_ptr) + k;
            if (v_sum >= NUM_REQS) v_sum = v_sum - NUM_REQS;
            if (!w_grant_found && req_valid[PTR_BITS'(v_sum)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = PTR_BITS'(v_sum);
            end
        end
    end

    assign w_next_ptr = (w_grant_idx == PTR_BITS'(NUM_REQS - 1)) ? '0 : w_grant_idx + PTR_BITS'(1);

    // Gated by reset so req_ready reads 0 while reset is held.
    assign w_accept = (r_state == ST_IDLE) && w_grant_found && !reset;

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_grant_idx] = 1'b1;
    end

    assign w_lane      = lowest_lane(r_hold.tmask);
    assign w_mask_next = r_hold.tmask & ~(NUM_LANES'(1) << w_lane);

    assign frag_data.pos_x    = r_hold.pos_x[w_lane];
    assign frag_data.pos_y    = r_hold.pos_y[w_lane];
    assign frag_data.color    = r_hold.color[w_lane];
    assign frag_data.depth    = r_hold.depth[w_lane];
    assign frag_data.backface = r_hold.backface[w_lane];

    assign frag_valid = (r_state == ST_ISSUE) && !w_hazard && !w_full;
    assign w_fire     = frag_valid && frag_ready;

    // Once offered, the tag is frozen so a done freeing a lower entry
    // cannot change frag_tag underneath a stalled handshake.
    assign frag_tag = r_tag_locked ? r_tag_lock : w_free_tag;

    assign busy = (r_state != ST_IDLE) || w_any_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_hold       <= '0;
            r_tag_locked <= 1'b0;
            r_tag_lock   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rr_ptr <= w_next_ptr;
                        r_hold   <= req_data[w_grant_idx];
                        if (|req_data[w_grant_idx].tmask) r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_fire) begin
                        r_hold.tmask <= w_mask_next;
                        r_tag_locked <= 1'b0;
                        if (w_mask_next == '0) r_state <= ST_IDLE;
                    end else if (frag_valid) begin
                        r_tag_locked <= 1'b1;
                        r_tag_lock   <= frag_tag;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    rop_inflight_table #(
        .INFLIGHT   (INFLIGHT),
        .TAG_BITS   (TAG_BITS)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .i_query_x  (frag_data.pos_x),
        .i_query_y  (frag_data.pos_y),
        .i_alloc    (w_fire),
        .i_alloc_tag(frag_tag),
        .i_free     (done_valid),
        .i_free_tag (done_tag),
        .o_hazard   (w_hazard),
        .o_full     (w_full),
        .o_any_valid(w_any_valid),
        .o_free_tag (w_free_tag)
    );

`ifdef ROP_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_frags         <= '0;
            perf_hazard_stalls <= '0;
            perf_full_stalls   <= '0;
        end else begin
            if (w_fire) perf_frags <= perf_frags + 32'd1;
            if (r_state == ST_ISSUE && w_hazard) perf_hazard_stalls <= perf_hazard_stalls + 32'd1;
            if (r_state == ST_ISSUE && !w_hazard && w_full) perf_full_stalls <= perf_full_stalls + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rop_frag_scheduler.sv
// ============================================================================
// Module      : tb_rop_frag_scheduler
// Description : Directed self-checking bench for rop_frag_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rop_frag_scheduler;
    import rop_frag_scheduler_pkg::*;

    localparam int NREQ = 4;
    localparam int TB   = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    rop_req_t [NREQ-1:0]  req_data;
    logic                 frag_valid;
    logic                 frag_ready;
    rop_frag_t            frag_data;
    logic [TB-1:0]        frag_tag;
    logic                 done_valid;
    logic [TB-1:0]        done_tag;
    logic                 busy;
`ifdef ROP_SCHED_PERF_EN
    logic [31:0]          perf_frags;
    logic [31:0]          perf_hazard_stalls;
    logic [31:0]          perf_full_stalls;
`endif

    int vectors     = 0;
    int miscompares = 0;

    rop_frag_scheduler #(.NUM_REQS(NREQ), .INFLIGHT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .frag_valid (frag_valid),
        .frag_ready (frag_ready),
        .frag_data  (frag_data),
        .frag_tag   (frag_tag),
        .done_valid (done_valid),
        .done_tag   (done_tag),
        .busy       (busy)
`ifdef ROP_SCHED_PERF_EN
        ,
        .perf_frags         (perf_frags),
        .perf_hazard_stalls (perf_hazard_stalls),
        .perf_full_stalls   (perf_full_stalls)
`endif
    );

    always #5 clk = ~clk;

    function automatic rop_req_t make_req(input logic [3:0] m, input int x0, input int y0,
                                          input int dx, input int dy);
        rop_req_t r;
        r = '0;
        r.tmask = m;
        for (int l = 0; l < 4; l++) begin
            r.pos_x[l]    = POS_BITS'(x0 + l * dx);
            r.pos_y[l]    = POS_BITS'(y0 + l * dy);
            r.color[l]    = 32'hC0DE_0000 + 32'(l);
            r.depth[l]    = DEPTH_BITS'(100 + l);
            r.backface[l] = l[0];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        frag_ready = 1'b1;
        done_valid = 1'b0;
        done_tag   = '0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic send_req(input int port, input rop_req_t r);
        int n;
        n = 0;
        req_data[port] = r;
        req_valid      = NREQ'(1) << port;
        #1;
        while (req_ready[port] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        vectors++;
        if (n >= 50) begin
            miscompares++;
            $display("FAIL send_req port %0d: req_ready never rose within 50 cycles", port);
        end
        step();
        req_valid = '0;
    endtask

    task automatic free_tag(input int t);
        done_valid = 1'b1;
        done_tag   = TB'(t);
        step();
        done_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        frag_ready = 1'b1;
        done_valid = 1'b0;
        done_tag   = '0;
        for (int p = 0; p < NREQ; p++) req_data[p] = make_req(4'b0001, p, 0, 0, 0);
        req_valid = '1;
        #1;
        vectors++;
        if (req_ready !== 4'b0000 || frag_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: req_ready=%b frag_valid=%b busy=%b, expected 0000/0/0",
                     req_ready, frag_valid, busy);
        end
        step();
        step();
        req_valid = '0;
        reset     = 1'b0;
        #1;
        vectors++;
        if (frag_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_release: frag_valid=%b busy=%b req_ready=%b, expected 0/0/0000",
                     frag_valid, busy, req_ready);
        end
    endtask

    task automatic test_serialize();
        int lanes [3] = '{0, 1, 3};
        do_reset();
        send_req(0, make_req(4'b1011, 1, 1, 1, 1));
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (frag_valid !== 1'b1 || frag_tag !== TB'(i) ||
                frag_data.pos_x !== POS_BITS'(1 + lanes[i]) ||
                frag_data.color !== 32'hC0DE_0000 + 32'(lanes[i])) begin
                miscompares++;
                $display("FAIL serialize[%0d]: valid=%b tag=%0d x=%0d color=%h, expected 1/%0d/%0d/%h",
                         i, frag_valid, frag_tag, frag_data.pos_x, frag_data.color,
                         i, 1 + lanes[i], 32'hC0DE_0000 + 32'(lanes[i]));
            end
            step();
        end
        vectors++;
        if (frag_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL serialize_end: frag_valid=%b busy=%b, expected 0/1", frag_valid, busy);
        end
        for (int t = 0; t < 3; t++) free_tag(t);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL serialize_drain: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int exp_p;
        do_reset();
        for (int p = 0; p < NREQ; p++) req_data[p] = make_req(4'b0001, 10 + p, 20, 0, 0);
        req_valid = '1;
        #1;
        for (int i = 0; i < 5; i++) begin
            exp_p = i % 4;
            vectors++;
            if (req_ready !== (NREQ'(1) << exp_p)) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: req_ready=%b, expected port %0d", i, req_ready, exp_p);
            end
            step();
            if (i == 4) req_valid = '0;
            if (i > 0) begin
                done_valid = 1'b1;
                done_tag   = TB'((i - 1) % 2);
            end
            #1;
            vectors++;
            if (frag_valid !== 1'b1 || frag_data.pos_x !== POS_BITS'(10 + exp_p) ||
                frag_tag !== TB'(i % 2)) begin
                miscompares++;
                $display("FAIL rr_frag[%0d]: valid=%b x=%0d tag=%0d, expected 1/%0d/%0d",
                         i, frag_valid, frag_data.pos_x, frag_tag, 10 + exp_p, i % 2);
            end
            step();
            done_valid = 1'b0;
        end
        free_tag(0);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_drain: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        send_req(0, make_req(4'b0011, 5, 7, 0, 0));
        vectors++;
        if (frag_valid !== 1'b1 || frag_tag !== 3'd0) begin
            miscompares++;
            $display("FAIL hazard_first: valid=%b tag=%0d, expected 1/0", frag_valid, frag_tag);
        end
        step();
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (frag_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL hazard_block[%0d]: frag_valid=%b, expected 0", c, frag_valid);
            end
            step();
        end
        done_valid = 1'b1;
        done_tag   = 3'd0;
        #1;
        vectors++;
        if (frag_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hazard_done_same_cycle: frag_valid=%b, expected 0", frag_valid);
        end
        step();
        done_valid = 1'b0;
        vectors++;
        if (frag_valid !== 1'b1 || frag_tag !== 3'd0 ||
            frag_data.pos_x !== POS_BITS'(5) || frag_data.pos_y !== POS_BITS'(7)) begin
            miscompares++;
            $display("FAIL hazard_release: valid=%b tag=%0d pos=(%0d,%0d), expected 1/0/(5,7)",
                     frag_valid, frag_tag, frag_data.pos_x, frag_data.pos_y);
        end
        step();
        free_tag(0);
    endtask

    task automatic test_full();
        do_reset();
        send_req(0, make_req(4'b1111, 30, 0, 1, 0));
        for (int c = 0; c < 4; c++) step();
        send_req(1, make_req(4'b1111, 40, 0, 1, 0));
        for (int c = 0; c < 4; c++) step();
        send_req(2, make_req(4'b0001, 50, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (frag_valid !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL full_block[%0d]: frag_valid=%b busy=%b, expected 0/1", c, frag_valid, busy);
            end
            step();
        end
        free_tag(3);
        vectors++;
        if (frag_valid !== 1'b1 || frag_tag !== 3'd3 || frag_data.pos_x !== POS_BITS'(50)) begin
            miscompares++;
            $display("FAIL full_release: valid=%b tag=%0d x=%0d, expected 1/3/50",
                     frag_valid, frag_tag, frag_data.pos_x);
        end
        step();
        for (int t = 0; t < 8; t++) free_tag(t);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_drain: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_stall();
        do_reset();
        frag_ready = 1'b0;
        send_req(2, make_req(4'b0001, 9, 9, 0, 0));
        req_valid = '1;
        #1;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (frag_valid !== 1'b1 || frag_tag !== 3'd0 || frag_data.pos_x !== POS_BITS'(9) ||
                req_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall[%0d]: valid=%b tag=%0d x=%0d req_ready=%b, expected 1/0/9/0000",
                         c, frag_valid, frag_tag, frag_data.pos_x, req_ready);
            end
            step();
        end
        frag_ready = 1'b1;
        step();
        req_valid = '0;
        #1;
        vectors++;
        if (frag_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_done: frag_valid=%b busy=%b, expected 0/1", frag_valid, busy);
        end
        free_tag(0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_req(0, make_req(4'b1111, 60, 0, 1, 0));
        for (int c = 0; c < 4; c++) step();
        send_req(1, make_req(4'b1111, 70, 0, 1, 0));
        step();
        vectors++;
        if (busy !== 1'b1 || frag_valid !== 1'b1 || frag_tag !== 3'd5) begin
            miscompares++;
            $display("FAIL midreset_pre: busy=%b valid=%b tag=%0d, expected 1/1/5", busy, frag_valid, frag_tag);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || frag_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_hold: busy=%b frag_valid=%b, expected 0/0", busy, frag_valid);
        end
        step();
        reset = 1'b0;
        #1;
        send_req(3, make_req(4'b0001, 60, 0, 0, 0));
        vectors++;
        if (frag_valid !== 1'b1 || frag_tag !== 3'd0) begin
            miscompares++;
            $display("FAIL midreset_new: valid=%b tag=%0d, expected 1/0", frag_valid, frag_tag);
        end
        step();
        free_tag(0);
    endtask

    initial begin
        req_data = '0;
        test_reset();
        test_serialize();
        test_round_robin();
        test_hazard();
        test_full();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
